// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes, bus widths and the command-master state encoding.
// ST_DRAIN exists only when AXIL_CMD_MASTER_TIMEOUT_EN is defined.
package axil_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WR_RESP,
        ST_READ,
        ST_RD_DATA,
        ST_RSP
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        , ST_DRAIN
`endif
    } axil_state_e;

endpackage

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master turning a valid/ready command port into single read/write bursts.
// Define AXIL_CMD_MASTER_TIMEOUT_EN to add the response watchdog and DRAIN state.
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 32,
    parameter logic [2:0] PROT           = 3'b000,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [STRB_W-1:0]     cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,

    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [STRB_W-1:0]     m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    axil_state_e             state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]       wdata_reg, wdata_next;
    logic [STRB_W-1:0]       wstrb_reg, wstrb_next;
    logic                    awvalid_reg, awvalid_next;
    logic                    wvalid_reg, wvalid_next;
    logic                    bready_reg, bready_next;
    logic                    arvalid_reg, arvalid_next;
    logic                    rready_reg, rready_next;
    logic                    rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]       rsp_rdata_reg, rsp_rdata_next;
    logic [1:0]              rsp_resp_reg, rsp_resp_next;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0]             cnt_reg, cnt_next;
    logic                    rsp_timeout_reg, rsp_timeout_next;
    // b_pend/r_pend remember which AXI response is still owed after a timeout
    logic                    b_pend_reg, b_pend_next;
    logic                    r_pend_reg, r_pend_next;
    logic                    drain_active;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            wstrb_reg       <= '0;
            awvalid_reg     <= 1'b0;
            wvalid_reg      <= 1'b0;
            bready_reg      <= 1'b0;
            arvalid_reg     <= 1'b0;
            rready_reg      <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= '0;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
            cnt_reg         <= '0;
            rsp_timeout_reg <= 1'b0;
            b_pend_reg      <= 1'b0;
            r_pend_reg      <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            wstrb_reg       <= wstrb_next;
            awvalid_reg     <= awvalid_next;
            wvalid_reg      <= wvalid_next;
            bready_reg      <= bready_next;
            arvalid_reg     <= arvalid_next;
            rready_reg      <= rready_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_resp_reg    <= rsp_resp_next;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
            cnt_reg         <= cnt_next;
            rsp_timeout_reg <= rsp_timeout_next;
            b_pend_reg      <= b_pend_next;
            r_pend_reg      <= r_pend_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        awvalid_next   = awvalid_reg;
        wvalid_next    = wvalid_reg;
        bready_next    = bready_reg;
        arvalid_next   = arvalid_reg;
        rready_next    = rready_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_resp_next  = rsp_resp_reg;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        cnt_next         = cnt_reg;
        rsp_timeout_next = rsp_timeout_reg;
        b_pend_next      = b_pend_reg;
        r_pend_next      = r_pend_reg;
        drain_active     = 1'b0;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_next  = cmd_addr;
                    wdata_next = cmd_wdata;
                    wstrb_next = cmd_wstrb;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
                    cnt_next         = '0;
                    rsp_timeout_next = 1'b0;
`endif
                    if (cmd_we) begin
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = ST_WRITE;
                    end else begin
                        arvalid_next = 1'b1;
                        state_next   = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                // address and data channels retire independently
                if (awvalid_reg && m_axi_awready) awvalid_next = 1'b0;
                if (wvalid_reg && m_axi_wready)   wvalid_next  = 1'b0;
                if (!awvalid_next && !wvalid_next) begin
                    bready_next = 1'b1;
                    state_next  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (bready_reg && m_axi_bvalid) begin
                    rsp_resp_next  = m_axi_bresp;
                    rsp_rdata_next = '0;
                    bready_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = ST_RSP;
                end
            end
            ST_READ: begin
                if (arvalid_reg && m_axi_arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (rready_reg && m_axi_rvalid) begin
                    rsp_rdata_next = m_axi_rdata;
                    rsp_resp_next  = m_axi_rresp;
                    rready_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = ST_IDLE;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
                    if (rsp_timeout_reg) state_next = ST_DRAIN;
`endif
                end
            end
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
            ST_DRAIN: begin
                if (!b_pend_reg && !r_pend_reg) state_next = ST_IDLE;
            end
`endif
            default: state_next = ST_IDLE;
        endcase

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        // watchdog: a normal completion in the same cycle takes priority
        if (state_reg inside {ST_WRITE, ST_WR_RESP, ST_READ, ST_RD_DATA}) begin
            cnt_next = cnt_reg + 16'd1;
            if (state_next == state_reg && cnt_reg >= TIMEOUT_LAST) begin
                state_next       = ST_RSP;
                rsp_valid_next   = 1'b1;
                rsp_resp_next    = RESP_SLVERR;
                rsp_rdata_next   = '0;
                rsp_timeout_next = 1'b1;
                b_pend_next      = (state_reg == ST_WRITE) || (state_reg == ST_WR_RESP);
                r_pend_next      = (state_reg == ST_READ) || (state_reg == ST_RD_DATA);
            end
        end

        // after a timeout, finish whatever handshakes are still open without reporting them
        drain_active = (state_reg == ST_DRAIN) || (state_reg == ST_RSP && rsp_timeout_reg);
        if (drain_active) begin
            awvalid_next = awvalid_reg && !m_axi_awready;
            wvalid_next  = wvalid_reg && !m_axi_wready;
            arvalid_next = arvalid_reg && !m_axi_arready;
            b_pend_next  = b_pend_reg && !(bready_reg && m_axi_bvalid);
            r_pend_next  = r_pend_reg && !(rready_reg && m_axi_rvalid);
            bready_next  = b_pend_next && !awvalid_next && !wvalid_next;
            rready_next  = r_pend_next && !arvalid_next;
        end
`endif
    end

    assign cmd_ready     = (state_reg == ST_IDLE) && !areset;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_rdata     = rsp_rdata_reg;
    assign rsp_resp      = rsp_resp_reg;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    assign rsp_timeout   = rsp_timeout_reg;
`else
    assign rsp_timeout   = 1'b0;
`endif

    assign m_axi_awaddr  = addr_reg;
    assign m_axi_awprot  = PROT;
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wdata   = wdata_reg;
    assign m_axi_wstrb   = wstrb_reg;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_bready  = bready_reg;
    assign m_axi_araddr  = addr_reg;
    assign m_axi_arprot  = PROT;
    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_rready  = rready_reg;

endmodule
